// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the EX-stage multiply/divide sequencer
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ge;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});

        // The shifted-out remainder MSB means the trial value is >= 2**WIDTH, so it always subtracts
        // and the low WIDTH bits of the difference are exact.
        rem_sh           = acc[2*WIDTH-2:WIDTH-1];
        {borrow, diff}   = {1'b0, rem_sh} - {1'b0, operand};
        ge               = acc[2*WIDTH-1] | ~borrow;

        if (is_div) begin
            acc_nxt = {(ge ? diff : rem_sh), acc[WIDTH-2:0], ge};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall
module ex_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hilo_rd,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               is_div_q;
    logic               sign_res_q;
    logic               sign_rem_q;
    logic               b_zero_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;

    logic               is_signed;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign is_signed = ~op[0];
    assign rs_neg    = is_signed & rs_val[WIDTH-1];
    assign rt_neg    = is_signed & rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
    assign accept    = (state == IDLE) & start & ~flush;
    assign last_iter = (cnt == CNT_W'(WIDTH-1));
    assign quot      = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hilo_rd | wr_hi | wr_lo);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .operand (opnd_q),
        .is_div  (is_div_q),
        .acc_nxt (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ITER;
            ITER:    if (flush) state_nxt = IDLE;
                     else if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            is_div_q   <= 1'b0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            b_zero_q   <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (accept) begin
                        is_div_q   <= op[1];
                        sign_res_q <= rs_neg ^ rt_neg;
                        sign_rem_q <= rs_neg;
                        b_zero_q   <= (rt_val == '0);
                        // Low half holds the multiplier (mul) or the dividend bits still to shift in (div).
                        opnd_q     <= op[1] ? rt_mag : rs_mag;
                        acc_q      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                        cnt        <= '0;
                    end
                end
                ITER: begin
                    if (!flush) begin
                        acc_q <= acc_step;
                        cnt   <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div_q) begin
                            div_zero <= b_zero_q;
                            lo       <= b_zero_q ? {WIDTH{1'b1}} : (sign_res_q ? (~quot + 1'b1) : quot);
                            hi       <= sign_rem_q ? (~rem + 1'b1) : rem;
                        end else begin
                            {hi, lo} <= sign_res_q ? (~acc_q + 1'b1) : acc_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - directed self-checking bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    ex_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .hilo_rd  (hilo_rd),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_n++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ez);
        int cyc, bn;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start = 1'b0;
        wait_done(cyc, bn);
        chk({tag, "_lat"}, cyc, 33);
        chk({tag, "_busy"}, bn, 33);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_dz"}, div_zero, ez);
        tick();
        chk({tag, "_done_drop"}, done, 0);
    endtask

    initial begin
        int cyc, bn;
        logic saw_done;
        logic stall_bad;

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", div_zero, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

        // Flush at cycle 10 with preloaded HI/LO
        wr_hi = 1'b1; wdata = 32'h1234;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678;
        tick();
        wr_lo = 1'b0;
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);
        start = 1'b1; op = 2'b11; rs_val = 32'd1000; rt_val = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", busy, 0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("flush_no_done", saw_done, 0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h5678);

        // Hazards while busy, then back-to-back start in the done cycle
        start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("haz_idle_nostall", stall, 0);
        hilo_rd = 1'b1;
        #1;
        chk("haz_rd_stall", stall, 1);
        start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
        stall_bad = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            if (!stall) stall_bad = 1'b1;
            tick();
            cyc++;
        end
        chk("haz_stall_held", stall_bad, 0);
        chk("haz_done", done, 1);
        chk("haz_done_stall", stall, 0);
        chk("haz_first_lo", lo, 32'd15);
        chk("haz_first_hi", hi, 32'd0);
        tick();
        start   = 1'b0;
        hilo_rd = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done(cyc, bn);
        chk("b2b_lat", cyc, 33);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);
        tick();

        // Asynchronous reset in the middle of a MULT
        start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_FFF9; rt_val = 32'd6;
        tick();
        start = 1'b0;
        repeat (19) tick();
        chk("arst_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        tick();
        reset = 1'b1;
        tick();
        run_op("post_rst", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that sits beside the EX-stage ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the HI/LO registers.
- Drives a stall to hazard logic so the IF/ID/EX pipeline registers hold while the result is pending.
- Performs one shift-add or shift-subtract step per clock using a radix-2 datapath.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- start  in  1  EX-stage instruction is a mul/div op; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- flush  in  1  squash the in-flight operation (branch taken / exception)
- hilo_rd  in  1  EX-stage instruction is MFHI or MFLO
- wr_hi  in  1  MTHI write
- wr_lo  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  state != IDLE
- stall  out  1  pipeline hold request, combinational
- done  out  1  one-cycle completion pulse, registered
- div_zero  out  1  last completed divide had rt_val == 0, registered
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE; counter = 0; hi = 0; lo = 0; done = 0; div_zero = 0; busy = 0.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - start == 1 and flush == 0: latch op; latch |rs_val| and |rt_val| for signed ops, raw values for unsigned ops.
  - Latch sign_res = rs[MSB] ^ rt[MSB] and sign_rem = rs[MSB]; both are 0 for unsigned ops.
  - Clear the 2*WIDTH accumulator and the counter, then go to ITER.
- ITER:
  - One step per cycle.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper half; then shift right 1.
  - Divide (restoring): shift the {rem, quot} pair left 1, trial-subtract the divisor, keep the result if non-negative and set the quotient LSB.
  - Counter increments each cycle; after WIDTH cycles (counter == WIDTH-1) go to FIX.
- FIX (one cycle):
  - Apply the sign correction in a dedicated cycle.
  - Mult: {hi, lo} = sign_res ? -product : product.
  - Div: lo = sign_res ? -quot : quot; hi = sign_rem ? -rem : rem.
  - done <= 1 for exactly the next cycle; go to IDLE.
- Latency: start sampled at edge E0; new hi/lo and done == 1 are visible after edge E(WIDTH+1), i.e. 33 cycles for WIDTH = 32. done returns to 0 after one cycle.
- Divide by zero: normal latency; result hi = original rs_val, lo = all ones; div_zero = 1.
- div_zero is updated only at divide completion and cleared by the next completed divide that has a nonzero divisor.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is the natural wrap of the magnitude arithmetic, with no special case.
- stall = (state != IDLE) & (start | hilo_rd | wr_hi | wr_lo).
  - A start seen while busy is ignored, and stall holds that instruction in EX until IDLE.
- MTHI/MTLO:
  - Write in IDLE only; wr_hi loads hi, wr_lo loads lo.
  - If start and a write are asserted in the same IDLE cycle, the write takes effect and start is also accepted; the later FIX overwrites both registers.
- flush: in ITER or FIX, return to IDLE at the next edge. hi, lo and div_zero are unchanged; no done pulse.
- flush together with start in IDLE: start is ignored.
- Reset asserted mid-operation: abort immediately to reset values.
- A back-to-back start in the cycle done is high (state IDLE) is accepted.

Decomposition:
- Shared package, muldiv_pkg:
  - op encodings MULT/MULTU/DIV/DIVU;
  - FSM state localparams IDLE/ITER/FIX;
  - WIDTH default.
- One sub-module, muldiv_step: combinational single-iteration step.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
  - Keeps the FSM module free of arithmetic.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001; done pulses exactly 33 cycles after start; busy high for 33 cycles.
- MULT -7 × 6: hi = 0xFFFFFFFF, lo = 0xFFFFFFD6.
- DIV -7 / 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 7: lo = 14, hi = 2, div_zero = 0.
- DIVU 5 / 0: lo = 0xFFFFFFFF, hi = 5, div_zero = 1.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Flush at cycle 10 of a DIVU with hi/lo preloaded by MTHI 0x1234 / MTLO 0x5678: state returns to IDLE next cycle; hi/lo remain 0x1234/0x5678; no done pulse.
- Hazards while busy: hilo_rd or start raised mid-operation gives stall == 1 until the done cycle, then stall drops. The second start is accepted in the done cycle and finishes 33 cycles later.
- Reset pulled low at cycle 20 of a MULT: busy, done, hi and lo go to 0 asynchronously, before the next clock edge; the sequencer accepts a new start after reset is released.
